// File: rtl/UART_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : UART_csr_pkg
// Brief    : CSR field encodings shared by the UART register block and datapath.
// Revision : 1.0 - initial release
// ============================================================================
package UART_csr_pkg;

  typedef enum logic {
    UART_SET_PARITY_OFF = 1'b0,
    UART_SET_PARITY_ON  = 1'b1
  } uart_set_parity_e;

  typedef enum logic {
    UART_PARITY_EVEN = 1'b0,
    UART_PARITY_ODD  = 1'b1
  } uart_parity_e;

  typedef enum logic {
    UART_BUSY_IDLE   = 1'b0,
    UART_BUSY_ACTIVE = 1'b1
  } uart_busy_e;

endpackage
`default_nettype wire

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Types and constants shared by the UART transmitter and receiver.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  localparam int   UART_MIN_DATA_BITS = 5;
  localparam logic UART_IDLE_LEVEL    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_if
// Brief    : Valid/ready word handshake between the send FIFO and uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
  parameter int DATA_WIDTH = 9
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Brief    : Bit-period counter; bit_done_o marks the last cycle of each bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
  parameter int BAUD_WIDTH = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  load_i,
  input  wire logic [BAUD_WIDTH-1:0] period_i,
  input  wire logic                  clear_i,
  input  wire logic                  enable_i,
  output logic                       bit_done_o
);

  localparam logic [BAUD_WIDTH-1:0] C_ONE = BAUD_WIDTH'(1);

  logic [BAUD_WIDTH-1:0] period_q, period_d;
  logic [BAUD_WIDTH-1:0] count_q, count_d;

  assign bit_done_o = enable_i && (count_q == (period_q - C_ONE));

  always_comb begin
    period_d = period_q;
    count_d  = count_q;
    if (load_i) begin
      // A zero divisor behaves as one cycle per bit.
      period_d = (period_i == '0) ? C_ONE : period_i;
      count_d  = '0;
    end else if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = bit_done_o ? '0 : (count_q + C_ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= C_ONE;
      count_q  <= '0;
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : UART serial transmitter (start, N data LSB first, parity, stop).
//            UART_TX_TWO_STOP_BITS_EN selects two stop bits instead of one.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
  import UART_csr_pkg::*;
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = 9,
  parameter int BAUD_WIDTH    = 32,
  parameter int MIN_DATA_BITS = UART_MIN_DATA_BITS
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic [BAUD_WIDTH-1:0] baud_rate_i,
  input  wire logic [3:0]            data_bits_i,
  input  wire logic                  parity_en_i,
  input  wire logic                  odd_parity_i,
  uart_tx_if.slave                   tx_if,
  output logic                       tx_o,
  output logic                       busy_o,
  output logic                       cfg_error_o
);

  localparam logic [3:0] C_MIN_BITS = 4'(MIN_DATA_BITS);
  localparam logic [3:0] C_MAX_BITS = 4'(DATA_WIDTH);
`ifdef UART_TX_TWO_STOP_BITS_EN
  localparam logic [3:0] C_LAST_STOP = 4'd1;
`else
  localparam logic [3:0] C_LAST_STOP = 4'd0;
`endif

  uart_tx_state_e        state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            nbits_q, nbits_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  uart_set_parity_e      par_en_q, par_en_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  uart_busy_e            busy_q, busy_d;
  logic                  cfg_err_q, cfg_err_d;

  logic ready;
  logic legal;
  logic load;
  logic bit_done;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic [3:0] n,
                                       input uart_parity_e mode);
    logic p;
    p = (mode == UART_PARITY_ODD);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(n)) p ^= d[i];
    end
    return p;
  endfunction

  assign legal = (data_bits_i >= C_MIN_BITS) && (data_bits_i <= C_MAX_BITS);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    nbits_d   = nbits_q;
    bit_cnt_d = bit_cnt_q;
    par_en_d  = par_en_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    cfg_err_d = 1'b0;
    ready     = 1'b0;
    load      = 1'b0;

    case (state_q)
      IDLE: ready = 1'b1;
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          tx_d      = data_q[0];
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == (nbits_q - 4'd1)) begin
            bit_cnt_d = '0;
            if (par_en_q == UART_SET_PARITY_ON) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = UART_IDLE_LEVEL;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            data_d    = data_q >> 1;
            tx_d      = data_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d   = STOP;
          tx_d      = UART_IDLE_LEVEL;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_cnt_q == C_LAST_STOP) begin
            ready   = 1'b1;
            state_d = IDLE;
            tx_d    = UART_IDLE_LEVEL;
            busy_d  = UART_BUSY_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = UART_IDLE_LEVEL;
        busy_d  = UART_BUSY_IDLE;
      end
    endcase

    // Accept from IDLE or the last stop cycle; an illegal width drops the word.
    if (ready && tx_if.tx_valid) begin
      if (legal) begin
        state_d   = START;
        tx_d      = 1'b0;
        busy_d    = UART_BUSY_ACTIVE;
        load      = 1'b1;
        data_d    = tx_if.tx_data;
        nbits_d   = data_bits_i;
        bit_cnt_d = '0;
        par_en_d  = uart_set_parity_e'(parity_en_i);
        parity_d  = calc_parity(tx_if.tx_data, data_bits_i,
                                uart_parity_e'(odd_parity_i));
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      nbits_q   <= '0;
      bit_cnt_q <= '0;
      par_en_q  <= UART_SET_PARITY_OFF;
      parity_q  <= 1'b0;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= UART_BUSY_IDLE;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      nbits_q   <= nbits_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  uart_baud_gen #(
    .BAUD_WIDTH (BAUD_WIDTH)
  ) u_baud_gen (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .period_i   (baud_rate_i),
    .clear_i    (state_q == IDLE),
    .enable_i   (state_q != IDLE),
    .bit_done_o (bit_done)
  );

  assign tx_if.tx_ready = ready;
  assign tx_o           = tx_q;
  assign busy_o         = (busy_q == UART_BUSY_ACTIVE);
  assign cfg_error_o    = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx: per-cycle frame model plus
//            hand-computed frame patterns and lengths.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int DW = 9;
`ifdef UART_TX_TWO_STOP_BITS_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] baud = 32'd4;
  logic [3:0]  nbits = 4'd8;
  logic        par_en = 1'b0;
  logic        odd = 1'b0;
  logic        tx, busy, cfg_err;

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx #(
    .DATA_WIDTH    (DW),
    .BAUD_WIDTH    (32),
    .MIN_DATA_BITS (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_rate_i  (baud),
    .data_bits_i  (nbits),
    .parity_en_i  (par_en),
    .odd_parity_i (odd),
    .tx_if        (bus.slave),
    .tx_o         (tx),
    .busy_o       (busy),
    .cfg_error_o  (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: each accepted word becomes a list of line levels, one per clock.
  int exp_q[$];
  bit pend_err = 1'b0;

  function automatic void push_frame(input logic [31:0] b, input int n, input bit pe,
                                     input bit od, input logic [DW-1:0] d);
    int p;
    int bits[$];
    bit par;
    p   = (b == 0) ? 1 : int'(b);
    par = od;
    bits.push_back(0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(int'(d[i]));
      par ^= d[i];
    end
    if (pe) bits.push_back(int'(par));
    for (int s = 0; s < STOPS; s++) bits.push_back(1);
    foreach (bits[k]) for (int c = 0; c < p; c++) exp_q.push_back(bits[k]);
  endfunction

  always @(negedge clk) begin : model
    int e_tx;
    int e_busy;
    bit e_ready;
    if (rst) begin
      exp_q.delete();
      pend_err = 1'b0;
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_ready", bus.tx_ready, 1);
      check("rst_cfg_err", cfg_err, 0);
    end else begin
      e_tx = 1;
      e_busy = 0;
      if (exp_q.size() > 0) begin
        e_tx = exp_q.pop_front();
        e_busy = 1;
      end
      e_ready = (exp_q.size() == 0);
      check("tx_o", tx, e_tx);
      check("busy_o", busy, e_busy);
      check("tx_ready", bus.tx_ready, e_ready);
      check("cfg_error", cfg_err, pend_err);
      pend_err = 1'b0;
      if (bus.tx_valid && e_ready) begin
        if (nbits >= 4'd5 && int'(nbits) <= DW)
          push_frame(baud, int'(nbits), par_en, odd, bus.tx_data);
        else
          pend_err = 1'b1;
      end
    end
  end

  task automatic send(input logic [31:0] b, input int n, input bit pe, input bit od,
                      input logic [DW-1:0] d);
    @(posedge clk); #1;
    baud = b; nbits = 4'(n); par_en = pe; odd = od;
    bus.tx_data = d; bus.tx_valid = 1'b1;
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
  endtask

  // Records the line level at the first cycle of every bit while busy, plus frame length.
  task automatic capture(input int p, output logic [15:0] bits, output int len, output int tail1);
    int t;
    t = 0; bits = '0; len = 0; tail1 = 0;
    do begin
      @(negedge clk);
      t++;
      if (busy) begin
        if ((len % p) == 0 && (len / p) < 16) bits[len / p] = tx;
        tail1 = tx ? tail1 + 1 : 0;
        len++;
      end
    end while ((busy || len == 0) && t < 3000);
    check("capture_done", 32'(t < 3000), 1);
  endtask

  task automatic frame_check(input string name, input logic [31:0] b, input int n, input bit pe,
                             input bit od, input logic [DW-1:0] d, input logic [15:0] exp_bits,
                             input int exp_len);
    logic [15:0] bits;
    int len, tail1, nb, p;
    p  = (b == 0) ? 1 : int'(b);
    nb = 2 + n + int'(pe);
    send(b, n, pe, od, d);
    baud = 32'd9;  // CSR change mid-frame must not disturb the frame
    capture(p, bits, len, tail1);
    check({name, "_bits"}, 32'(bits & 16'((1 << nb) - 1)), 32'(exp_bits));
    check({name, "_len"}, len, exp_len);
  endtask

  initial begin : stim
    logic [15:0] bits;
    int len, tail1, cnt_err, cnt_busy, cnt_low, rdy, lowb, t;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (2) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_ready", bus.tx_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);

    frame_check("odd55", 32'd4, 8, 1, 1, 9'h055, 16'h06AA, 44 + 4 * (STOPS - 1));
    frame_check("even55", 32'd4, 8, 1, 0, 9'h055, 16'h04AA, 44 + 4 * (STOPS - 1));
    frame_check("n7ff", 32'd3, 7, 0, 0, 9'h0FF, 16'h01FE, 27 + 3 * (STOPS - 1));
    frame_check("baud0", 32'd0, 8, 0, 0, 9'h0A5, 16'h034A, 10 + (STOPS - 1));

    // Stop level: data 0x00 leaves only the stop bits high at the end.
    send(32'd4, 8, 0, 0, 9'h000);
    capture(4, bits, len, tail1);
    check("zero_len", len, 40 + 4 * (STOPS - 1));
    check("stop_hold", tail1, 4 * STOPS);

    // Illegal widths: consumed, one error pulse, line untouched.
    for (int k = 0; k < 2; k++) begin
      send(32'd4, (k == 0) ? 3 : 10, 0, 0, 9'h0AA);
      cnt_err = 0; cnt_busy = 0; cnt_low = 0;
      repeat (6) begin
        @(negedge clk);
        cnt_err += int'(cfg_err);
        cnt_busy += int'(busy);
        cnt_low += int'(!tx);
      end
      check(k == 0 ? "err3_pulses" : "err10_pulses", cnt_err, 1);
      check(k == 0 ? "err3_busy" : "err10_busy", cnt_busy, 0);
      check(k == 0 ? "err3_txlow" : "err10_txlow", cnt_low, 0);
    end

    // Back-to-back words with valid held, P=2, 8N1.
    @(posedge clk); #1;
    baud = 32'd2; nbits = 4'd8; par_en = 1'b0; odd = 1'b0;
    bus.tx_data = 9'h03C; bus.tx_valid = 1'b1;
    @(posedge clk); #1 bus.tx_data = 9'h0C3;
    rdy = 0; lowb = 0; t = 0;
    do begin
      @(negedge clk);
      t++;
      if (!busy) lowb++;
      if (bus.tx_ready) rdy++;
    end while (!bus.tx_ready && t < 200);
    @(posedge clk); #1 bus.tx_valid = 1'b0;
    check("b2b_ready_pulses", rdy, 1);
    check("b2b_busy_gap", lowb, 0);
    check("b2b_first_len", t, 20 + 2 * (STOPS - 1));
    capture(2, bits, len, tail1);
    check("b2b_second_bits", 32'(bits & 16'h03FF), 32'h0386);
    check("b2b_second_len", len, 20 + 2 * (STOPS - 1));

    // Reset during data bit 3 abandons the frame immediately.
    send(32'd4, 8, 0, 0, 9'h000);
    repeat (18) @(negedge clk);
    check("pre_rst_tx", tx, 0);
    check("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.tx_ready, 1);
    frame_check("post_rst", 32'd4, 8, 1, 1, 9'h055, 16'h06AA, 44 + 4 * (STOPS - 1));

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
